// File: rtl/vga_pkg.sv
// Display-mode encodings and the mode-advance rule, shared by the mode
// controller and the pattern generators that consume the committed mode.
package vga_pkg;

    typedef enum logic [1:0] {
        MODE_IDLE   = 2'd0,
        MODE_BAR    = 2'd1,
        MODE_CHAR   = 2'd2,
        MODE_CUSTOM = 2'd3
    } mode_t;

    // IDLE is only ever left; the cycle wraps CUSTOM back to BAR.
    function automatic mode_t mode_advance(input mode_t m);
        case (m)
            MODE_IDLE: return MODE_BAR;
            MODE_BAR:  return MODE_CHAR;
            MODE_CHAR: return MODE_CUSTOM;
            default:   return MODE_BAR;
        endcase
    endfunction

endpackage

// File: rtl/key_debounce.sv
// Two-flop synchronizer plus debounce for the active-low mode key; emits a
// single-cycle press pulse per debounced press.
module key_debounce #(
    parameter logic [19:0] DEB_CNT = 20'd999_999
) (
    input  logic sys_clk,
    input  logic sys_rst,
    input  logic key_n,
    output logic press
);

    logic [1:0]  r_sync;
    logic        r_down;
    logic [19:0] r_cnt;
    logic        r_press;
    logic        w_lvl_down;

    assign w_lvl_down = ~r_sync[1];

    // r_cnt runs only while the synchronized level disagrees with the
    // debounced state; DEB_CNT+1 agreeing samples flip the state.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_sync  <= 2'b11;
            r_down  <= 1'b0;
            r_cnt   <= '0;
            r_press <= 1'b0;
        end else begin
            r_sync  <= {r_sync[0], key_n};
            r_press <= 1'b0;
            if (w_lvl_down == r_down) begin
                r_cnt <= '0;
            end else if (r_cnt == DEB_CNT) begin
                r_cnt   <= '0;
                r_down  <= w_lvl_down;
                r_press <= w_lvl_down;
            end else begin
                r_cnt <= r_cnt + 20'd1;
            end
        end
    end

    assign press = r_press;

endmodule

// File: rtl/vga_mode_ctrl.sv
// Display-mode controller: merges key, UART command and auto-cycle requests
// into a pending mode that is committed only at frame_start.
module vga_mode_ctrl
    import vga_pkg::*;
#(
    parameter logic [19:0] DEB_CNT     = 20'd999_999,
    parameter logic [8:0]  AUTO_FRAMES = 9'd300
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic       key_n,
    input  logic       cmd_valid,
    input  logic [1:0] cmd_mode,
    output logic       cmd_ready,
    input  logic       auto_en,
    input  logic       frame_start,
    output logic [1:0] mode,
    output logic       mode_chg,
    output logic       pending
);

    mode_t      r_mode;
    mode_t      r_pend_mode;
    logic       r_pending;
    logic       r_mode_chg;
    logic       r_cmd_ready;
    logic [8:0] r_auto_cnt;

    logic       w_press;
    logic       w_cmd_acc;
    logic       w_commit;
    logic       w_auto_done;
    logic       w_adv;
    mode_t      w_base;

    key_debounce #(
        .DEB_CNT (DEB_CNT)
    ) u_key_debounce (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .key_n   (key_n),
        .press   (w_press)
    );

    assign w_cmd_acc   = cmd_valid & r_cmd_ready;
    assign w_commit    = frame_start & r_pending;
    assign w_auto_done = auto_en & frame_start & (r_auto_cnt == AUTO_FRAMES - 9'd1);
    assign w_adv       = w_press | w_auto_done;
    // In a commit cycle r_pend_mode is the value being committed, so it is
    // also the right base for a request arriving in that cycle.
    assign w_base      = r_pending ? r_pend_mode : r_mode;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_mode      <= MODE_IDLE;
            r_pend_mode <= MODE_IDLE;
            r_pending   <= 1'b0;
            r_mode_chg  <= 1'b0;
            r_cmd_ready <= 1'b1;
            r_auto_cnt  <= '0;
        end else begin
            r_mode_chg <= w_commit;
            if (w_commit)
                r_mode <= r_pend_mode;

            if (!auto_en || w_commit || w_auto_done)
                r_auto_cnt <= '0;
            else if (frame_start)
                r_auto_cnt <= r_auto_cnt + 9'd1;

            // Command beats key/auto; r_cmd_ready stays low until a
            // command-originated request has been committed.
            if (w_cmd_acc) begin
                r_pend_mode <= mode_t'(cmd_mode);
                r_pending   <= 1'b1;
                r_cmd_ready <= 1'b0;
            end else if (w_adv) begin
                r_pend_mode <= mode_advance(w_base);
                r_pending   <= 1'b1;
                if (w_commit)
                    r_cmd_ready <= 1'b1;
            end else if (w_commit) begin
                r_pending   <= 1'b0;
                r_cmd_ready <= 1'b1;
            end
        end
    end

    assign mode      = r_mode;
    assign mode_chg  = r_mode_chg;
    assign pending   = r_pending;
    assign cmd_ready = r_cmd_ready;

endmodule
